// File: rtl/midi_note_event_fifo_pkg.sv
// Shared MIDI constants, parser states and the packed FIFO event entry
// used by the note-event FIFO top and its storage sub-module.
package midi_note_event_fifo_pkg;

  localparam logic [3:0] NOTE_OFF   = 4'h8;
  localparam logic [3:0] NOTE_ON    = 4'h9;
  localparam logic [7:0] SYSEX_BASE = 8'hF0;
  localparam logic [7:0] RT_BASE    = 8'hF8;

  localparam int EVT_W = 20;

  typedef enum logic [1:0] {
    P_IDLE,
    P_WAIT_KEY,
    P_WAIT_VEL,
    P_SKIP
  } parse_state_t;

  // Entry layout {note_on, channel, key[6:0], vel[6:0], pad}
  typedef struct packed {
    logic       note_on;
    logic [3:0] channel;
    logic [6:0] key;
    logic [6:0] vel;
    logic       pad;
  } note_evt_t;

  function automatic logic is_note_status(input logic [7:0] b);
    return (b[7:4] == NOTE_ON) || (b[7:4] == NOTE_OFF);
  endfunction

endpackage

// File: rtl/midi_note_event_fifo_sync_fifo.sv
// Generic show-ahead FIFO: head entry is visible on rd_data while empty=0.
// A write into a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH      = 20,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic                  rd_eff, wr_eff;

  assign empty  = (count == '0);
  assign full   = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign rd_eff = rd_en && !empty;
  assign wr_eff = wr_en && (!full || rd_eff);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_eff) wr_ptr <= wr_ptr + 1'b1;
      if (rd_eff) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_eff, rd_eff})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the top gates outputs with empty.
  always_ff @(posedge clk) begin
    if (wr_eff) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/midi_note_event_fifo.sv
// MIDI byte-stream parser producing Note-On/Note-Off events into a show-ahead FIFO,
// with running status, transparent real-time bytes, channel filter and sticky overflow.
module midi_note_event_fifo
  import midi_note_event_fifo_pkg::*;
#(
  parameter int          DEPTH_LOG2   = 4,
  parameter logic [15:0] CHANNEL_MASK = 16'hFFFF,
  parameter bit          VEL0_IS_OFF  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_byte,
  input  logic                rx_byte_valid,
  input  logic                rd,
  input  logic                ovf_clr,
  output logic [7:0]          key,
  output logic [7:0]          velocity,
  output logic [3:0]          channel,
  output logic                note_on,
  output logic                empty,
  output logic                full,
  output logic [DEPTH_LOG2:0] count,
  output logic                overflow
);

  parse_state_t state, state_n;
  logic         run_on, run_on_n;
  logic [3:0]   run_ch, run_ch_n;
  logic [6:0]   key_q, key_n;
  logic         issue;
  note_evt_t    evt_n, evt_q;
  logic         evt_vld;
  logic [EVT_W-1:0] head_raw;
  note_evt_t    head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= P_IDLE;
      run_on <= 1'b0;
      run_ch <= '0;
      key_q  <= '0;
    end else begin
      state  <= state_n;
      run_on <= run_on_n;
      run_ch <= run_ch_n;
      key_q  <= key_n;
    end
  end

  always_comb begin
    state_n  = state;
    run_on_n = run_on;
    run_ch_n = run_ch;
    key_n    = key_q;
    issue    = 1'b0;
    // Real-time bytes (F8..FF) fall through untouched, even mid-message.
    if (rx_byte_valid && (rx_byte < RT_BASE)) begin
      if (rx_byte >= SYSEX_BASE) begin
        state_n  = P_IDLE;
        run_on_n = 1'b0;
        run_ch_n = '0;
      end else if (rx_byte[7]) begin
        if (is_note_status(rx_byte)) begin
          state_n  = P_WAIT_KEY;
          run_on_n = rx_byte[4];
          run_ch_n = rx_byte[3:0];
        end else begin
          state_n = P_SKIP;
        end
      end else begin
        case (state)
          P_WAIT_KEY: begin
            key_n   = rx_byte[6:0];
            state_n = P_WAIT_VEL;
          end
          P_WAIT_VEL: begin
            issue   = 1'b1;
            state_n = P_WAIT_KEY;
          end
          default: state_n = state;
        endcase
      end
    end
  end

  always_comb begin
    evt_n.note_on = run_on && !(VEL0_IS_OFF && (rx_byte[6:0] == 7'd0));
    evt_n.channel = run_ch;
    evt_n.key     = key_q;
    evt_n.vel     = rx_byte[6:0];
    evt_n.pad     = 1'b0;
  end

  // One-stage parse register between the velocity strobe and the FIFO write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_vld <= 1'b0;
      evt_q   <= '0;
    end else begin
      evt_vld <= issue && CHANNEL_MASK[run_ch];
      if (issue) evt_q <= evt_n;
    end
  end

  sync_fifo #(
    .WIDTH      (EVT_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (evt_vld),
    .wr_data (evt_q),
    .rd_en   (rd),
    .rd_data (head_raw),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          overflow <= 1'b0;
    else if (evt_vld && full && !rd)  overflow <= 1'b1;
    else if (ovf_clr)                 overflow <= 1'b0;
  end

  assign head     = note_evt_t'(head_raw);
  assign key      = empty ? 8'h00 : {1'b0, head.key};
  assign velocity = empty ? 8'h00 : {1'b0, head.vel};
  assign channel  = empty ? 4'h0  : head.channel;
  assign note_on  = empty ? 1'b0  : head.note_on;

endmodule

// File: tb/tb_midi_note_event_fifo.sv
// Directed bench: default instance, a ch0-only filtered instance and a depth-4 instance
// share one byte stream; each scenario resets and checks the relevant instance.
module tb_midi_note_event_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic rx_byte_valid = 1'b0;
  logic rd = 1'b0;
  logic ovf_clr = 1'b0;

  logic [7:0] key_a, vel_a, key_f, vel_f, key_o, vel_o;
  logic [3:0] ch_a, ch_f, ch_o;
  logic on_a, on_f, on_o, empty_a, empty_f, empty_o, full_a, full_f, full_o;
  logic ovf_a, ovf_f, ovf_o;
  logic [4:0] count_a, count_f;
  logic [2:0] count_o;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  midi_note_event_fifo dut_a (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid), .rd(rd), .ovf_clr(ovf_clr),
    .key(key_a), .velocity(vel_a), .channel(ch_a), .note_on(on_a), .empty(empty_a), .full(full_a),
    .count(count_a), .overflow(ovf_a));

  midi_note_event_fifo #(.CHANNEL_MASK(16'h0001)) dut_f (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid), .rd(rd), .ovf_clr(ovf_clr),
    .key(key_f), .velocity(vel_f), .channel(ch_f), .note_on(on_f), .empty(empty_f), .full(full_f),
    .count(count_f), .overflow(ovf_f));

  midi_note_event_fifo #(.DEPTH_LOG2(2)) dut_o (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid), .rd(rd), .ovf_clr(ovf_clr),
    .key(key_o), .velocity(vel_o), .channel(ch_o), .note_on(on_o), .empty(empty_o), .full(full_o),
    .count(count_o), .overflow(ovf_o));

  // All stimulus changes happen at negedge; outputs are sampled there too.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte = b;
    rx_byte_valid = 1'b1;
    tick();
    rx_byte_valid = 1'b0;
  endtask

  task automatic pop();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rd = 1'b0;
    ovf_clr = 1'b0;
    rx_byte_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if ({empty_a, full_a, ovf_a} !== 3'b100) $display("FAIL reset_flags: got %b want 100", {empty_a, full_a, ovf_a}); else passed++;
    total++; if (count_a !== 5'd0) $display("FAIL reset_count: got %0d want 0", count_a); else passed++;
    total++; if ({key_a, vel_a, ch_a, on_a} !== 21'h0) $display("FAIL reset_outputs: got %h want 0", {key_a, vel_a, ch_a, on_a}); else passed++;
  endtask

  task automatic test_single_note();
    do_reset();
    send(8'h90); send(8'h45); send(8'h55);
    total++; if (empty_a !== 1'b1) $display("FAIL latency_empty_n1: got %b want 1", empty_a); else passed++;
    tick();
    total++; if (empty_a !== 1'b0) $display("FAIL latency_empty_n2: got %b want 0", empty_a); else passed++;
    total++; if ({key_a, vel_a, ch_a, on_a} !== {8'h45, 8'h55, 4'h0, 1'b1})
      $display("FAIL single_head: got %h want %h", {key_a, vel_a, ch_a, on_a}, {8'h45, 8'h55, 4'h0, 1'b1}); else passed++;
    pop();
    total++; if (empty_a !== 1'b1 || {key_a, vel_a, ch_a, on_a} !== 21'h0)
      $display("FAIL single_pop: got empty=%b out=%h want empty=1 out=0", empty_a, {key_a, vel_a, ch_a, on_a}); else passed++;
  endtask

  task automatic test_running_status();
    do_reset();
    send(8'h91); send(8'h30); send(8'h7F); send(8'h30); send(8'h00); tick();
    total++; if (count_a !== 5'd2) $display("FAIL running_count: got %0d want 2", count_a); else passed++;
    total++; if ({key_a, vel_a, ch_a, on_a} !== {8'h30, 8'h7F, 4'h1, 1'b1})
      $display("FAIL running_ev0: got %h want %h", {key_a, vel_a, ch_a, on_a}, {8'h30, 8'h7F, 4'h1, 1'b1}); else passed++;
    pop();
    total++; if ({key_a, vel_a, ch_a, on_a} !== {8'h30, 8'h00, 4'h1, 1'b0})
      $display("FAIL running_ev1_vel0_off: got %h want %h", {key_a, vel_a, ch_a, on_a}, {8'h30, 8'h00, 4'h1, 1'b0}); else passed++;
    pop();
    total++; if (empty_a !== 1'b1) $display("FAIL running_drain: got empty=%b want 1", empty_a); else passed++;
  endtask

  task automatic test_realtime_sysex();
    do_reset();
    send(8'h90); send(8'hF8); send(8'h40); send(8'hFE); send(8'h20); tick();
    total++; if (count_a !== 5'd1 || {key_a, vel_a, ch_a, on_a} !== {8'h40, 8'h20, 4'h0, 1'b1})
      $display("FAIL realtime_event: got count=%0d out=%h want count=1 out=%h", count_a, {key_a, vel_a, ch_a, on_a}, {8'h40, 8'h20, 4'h0, 1'b1}); else passed++;
    pop();
    send(8'h90); send(8'h40); send(8'hF0); send(8'h20); tick();
    total++; if (count_a !== 5'd0) $display("FAIL sysex_abort: got count=%0d want 0", count_a); else passed++;
    // Running status must be gone: plain data bytes are dropped in IDLE.
    send(8'h30); send(8'h40); send(8'h31); tick();
    total++; if (count_a !== 5'd0) $display("FAIL sysex_idle_drop: got count=%0d want 0", count_a); else passed++;
    // Non-note status skips its data; a partial note is abandoned by a new status.
    send(8'hB0); send(8'h07); send(8'h7F); send(8'h45);
    send(8'h93); send(8'h11); send(8'h95); send(8'h22); send(8'h33); tick();
    total++; if (count_a !== 5'd1 || {key_a, vel_a, ch_a, on_a} !== {8'h22, 8'h33, 4'h5, 1'b1})
      $display("FAIL skip_restart: got count=%0d out=%h want count=1 out=%h", count_a, {key_a, vel_a, ch_a, on_a}, {8'h22, 8'h33, 4'h5, 1'b1}); else passed++;
  endtask

  task automatic test_filter();
    do_reset();
    send(8'h85); send(8'h3C); send(8'h10); send(8'h80); send(8'h3C); send(8'h10); tick();
    total++; if (count_f !== 5'd1) $display("FAIL filter_count: got %0d want 1", count_f); else passed++;
    total++; if ({key_f, vel_f, ch_f, on_f} !== {8'h3C, 8'h10, 4'h0, 1'b0})
      $display("FAIL filter_head: got %h want %h", {key_f, vel_f, ch_f, on_f}, {8'h3C, 8'h10, 4'h0, 1'b0}); else passed++;
    total++; if (count_a !== 5'd2 || ch_a !== 4'h5 || on_a !== 1'b0)
      $display("FAIL unfiltered_both: got count=%0d ch=%h on=%b want count=2 ch=5 on=0", count_a, ch_a, on_a); else passed++;
  endtask

  task automatic test_overflow();
    do_reset();
    send(8'h90);
    for (int i = 0; i < 5; i++) begin
      send(8'h10 + 8'(i));
      send(8'h01 + 8'(i));
    end
    tick();
    total++; if ({full_o, ovf_o} !== 2'b11 || count_o !== 3'd4)
      $display("FAIL ovf_state: got full=%b ovf=%b count=%0d want 1 1 4", full_o, ovf_o, count_o); else passed++;
    total++; if ({key_o, vel_o} !== {8'h10, 8'h01}) $display("FAIL ovf_head: got %h want 1001", {key_o, vel_o}); else passed++;
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    total++; if (ovf_o !== 1'b0) $display("FAIL ovf_clear: got %b want 0", ovf_o); else passed++;
    // Velocity strobe at edge N, pop on edge N+1 when the write lands.
    send(8'h15); send(8'h06);
    pop();
    total++; if (count_o !== 3'd4 || full_o !== 1'b1 || ovf_o !== 1'b0)
      $display("FAIL full_rd_wr: got count=%0d full=%b ovf=%b want 4 1 0", count_o, full_o, ovf_o); else passed++;
    total++; if (key_o !== 8'h11) $display("FAIL full_rd_wr_head: got %h want 11", key_o); else passed++;
    pop(); pop(); pop();
    total++; if ({key_o, vel_o, count_o} !== {8'h15, 8'h06, 3'd1})
      $display("FAIL wrap_tail: got %h want %h", {key_o, vel_o, count_o}, {8'h15, 8'h06, 3'd1}); else passed++;
  endtask

  task automatic test_rd_empty();
    do_reset();
    pop(); pop();
    total++; if (count_a !== 5'd0 || empty_a !== 1'b1) $display("FAIL rd_empty_count: got %0d want 0", count_a); else passed++;
    send(8'h92); send(8'h50); send(8'h60); tick();
    total++; if ({key_a, vel_a, ch_a, on_a, count_a} !== {8'h50, 8'h60, 4'h2, 1'b1, 5'd1})
      $display("FAIL rd_empty_then_write: got %h want %h", {key_a, vel_a, ch_a, on_a, count_a}, {8'h50, 8'h60, 4'h2, 1'b1, 5'd1}); else passed++;
  endtask

  task automatic test_reset_mid_message();
    do_reset();
    send(8'h90); send(8'h45);
    rst = 1'b1; tick(); rst = 1'b0; tick();
    send(8'h55); tick(); tick();
    total++; if (empty_a !== 1'b1 || count_a !== 5'd0)
      $display("FAIL reset_mid_msg: got empty=%b count=%0d want 1 0", empty_a, count_a); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_running_status();
    test_realtime_sysex();
    test_filter();
    test_overflow();
    test_rd_empty();
    test_reset_mid_message();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
